hynoc_egress_credit: RTL
========================

HYNOC_EGRESS_CREDIT -- requirements
Module: hynoc_egress_credit

Interface
REQ-001 SHALL have parameter NB_INPUTS, default 4: number of ingress sources competing for this output; minimum 2.
REQ-002 SHALL have parameter PAYLOAD_WIDTH, default 32: flit payload bits.
REQ-003 SHALL have parameter FLIT_WIDTH, default PAYLOAD_WIDTH+1: flit width, MSB = stop bit (last flit of packet).
REQ-004 SHALL have parameter CREDITS, default 8: downstream buffer depth in flits, minimum 1; CREDIT_WIDTH = clog2(CREDITS+1) derived.
REQ-005 SHALL have port router_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port router_srst  in  1  synchronous active-high reset.
REQ-007 SHALL have port from_ingress_request  in  NB_INPUTS  per-source packet request.
REQ-008 SHALL have port from_ingress_valid  in  NB_INPUTS  per-source flit valid.
REQ-009 SHALL have port from_ingress_data  in  NB_INPUTS*FLIT_WIDTH  source i at bits [(i+1)*FLIT_WIDTH-1 : i*FLIT_WIDTH].
REQ-010 SHALL have port to_ingress_grant  out  NB_INPUTS  one-hot or zero, registered.
REQ-011 SHALL have port to_ingress_ready  out  NB_INPUTS  flit accept strobe, nonzero only on the granted bit.
REQ-012 SHALL have port out_valid  out  1  registered flit strobe downstream.
REQ-013 SHALL have port out_data  out  FLIT_WIDTH  registered flit downstream.
REQ-014 SHALL have port credit_return  in  1  downstream freed one slot this cycle.
REQ-015 SHALL have port credit_err  out  1  sticky: credit_return received with counter already at CREDITS.

Function
REQ-016 SHALL implement FSM IDLE/LOCKED; IDLE: if any request, pick winner round-robin starting at (last_winner+1) mod NB_INPUTS, set grant bit, go LOCKED next cycle.
REQ-017 SHALL in LOCKED drive to_ingress_ready[sel] = (credit_cnt != 0), combinational from registered state; all other ready bits 0.
REQ-018 SHALL define transfer = LOCKED & from_ingress_valid[sel] & to_ingress_ready[sel]; transfer at cycle N gives out_valid=1, out_data=flit at N+1; otherwise out_valid=0, out_data holds.
REQ-019 SHALL on transfer with stop bit set return to IDLE, clear grant, record last_winner=sel; next arbitration no earlier than following cycle.
REQ-020 SHALL hold LOCKED (wormhole) if request drops mid-packet without stop bit; ignore request and valid of non-granted sources.
REQ-021 SHALL decrement credit_cnt on transfer, increment on credit_return, leave unchanged on both; never exceed CREDITS or go below 0.
REQ-022 SHALL, on credit_return with credit_cnt==CREDITS and no transfer, keep CREDITS and set credit_err.
REQ-023 SHALL allow single-flit packets (stop bit on first flit).

Reset
REQ-024 SHALL on router_srst: state IDLE, to_ingress_grant=0, out_valid=0, out_data=0, credit_cnt=CREDITS, credit_err=0, last_winner=NB_INPUTS-1 (source 0 first priority).
REQ-025 SHALL abort any packet in progress on reset mid-packet; no partial-packet completion afterwards.

Configuration
REQ-026 SHALL, with HYNOC_EGRESS_STATS_EN defined, add outputs stat_flits[31:0] and stat_packets[31:0], counting transfers and stop-bit transfers, wrapping at 2^32, cleared by reset; without it those ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-027 SHALL place FSM state encoding and the stop-bit index function in package hynoc_pkg, shared with ingress.
REQ-028 SHALL implement round-robin selection in sub-module hynoc_rr_pick (request vector + last_winner -> one-hot + index, combinational).

Verification
REQ-029 SHALL test: reset, request=4'b0101 -> grant=4'b0001 one cycle later; 3-flit packet from source 0 -> out_valid 3 cycles, next grant 4'b0100.
REQ-030 SHALL test: CREDITS=2, no credit_return, 4-flit packet -> only 2 flits out, ready low; one credit_return -> exactly one more flit.
REQ-031 SHALL test: transfer and credit_return same cycle -> credit_cnt unchanged.
REQ-032 SHALL test: credit_return at full credit -> credit_err=1, sticky until reset.
REQ-033 SHALL test: all 4 sources requesting single-flit packets continuously -> grants 0,1,2,3,0 in order.
REQ-034 SHALL test: reset asserted mid-packet -> all outputs at reset values next cycle, then fresh arbitration from source 0.

Source files
------------

// File: rtl/hynoc_pkg.sv
// rtl/hynoc_pkg.sv - shared router FSM state encoding and flit field helpers
package hynoc_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } hynoc_state_e;

  // The stop bit (last flit of a packet) is always the flit MSB.
  function automatic int stop_bit_idx(input int flit_width);
    return flit_width - 1;
  endfunction

endpackage

// File: rtl/hynoc_egress_credit_if.sv
// rtl/hynoc_egress_credit_if.sv - ingress handshake and downstream credit bus of one egress port
interface hynoc_egress_credit_if #(
  parameter int NB_INPUTS  = 4,
  parameter int FLIT_WIDTH = 33
);
  logic [NB_INPUTS-1:0]            from_ingress_request;
  logic [NB_INPUTS-1:0]            from_ingress_valid;
  logic [NB_INPUTS*FLIT_WIDTH-1:0] from_ingress_data;
  logic [NB_INPUTS-1:0]            to_ingress_grant;
  logic [NB_INPUTS-1:0]            to_ingress_ready;
  logic                            out_valid;
  logic [FLIT_WIDTH-1:0]           out_data;
  logic                            credit_return;
  logic                            credit_err;

  modport slave (
    input  from_ingress_request, from_ingress_valid, from_ingress_data, credit_return,
    output to_ingress_grant, to_ingress_ready, out_valid, out_data, credit_err
  );

  modport master (
    output from_ingress_request, from_ingress_valid, from_ingress_data, credit_return,
    input  to_ingress_grant, to_ingress_ready, out_valid, out_data, credit_err
  );
endinterface

// File: rtl/hynoc_rr_pick.sv
// rtl/hynoc_rr_pick.sv - combinational round-robin pick starting after the last winner
module hynoc_rr_pick #(
  parameter int NB_INPUTS = 4,
  parameter int IDX_W     = $clog2(NB_INPUTS)
) (
  input  logic [NB_INPUTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_winner,
  output logic [NB_INPUTS-1:0] o_onehot,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= NB_INPUTS; k++) begin
      w_cand = IDX_W'((int'(i_last_winner) + k) % NB_INPUTS);
      if (!o_any && i_req[w_cand]) begin
        o_any            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/hynoc_egress_credit.sv
// rtl/hynoc_egress_credit.sv - wormhole egress arbiter with downstream credit flow control
// Optional flit/packet counters are built when HYNOC_EGRESS_STATS_EN is defined.
module hynoc_egress_credit
  import hynoc_pkg::*;
#(
  parameter int NB_INPUTS     = 4,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int FLIT_WIDTH    = PAYLOAD_WIDTH + 1,
  parameter int CREDITS       = 8
) (
  input  logic                 router_clk,
  input  logic                 router_srst,
  hynoc_egress_credit_if.slave bus
`ifdef HYNOC_EGRESS_STATS_EN
  ,
  output logic [31:0]          stat_flits,
  output logic [31:0]          stat_packets
`endif
);

  localparam int CREDIT_WIDTH = $clog2(CREDITS + 1);
  localparam int IDX_W        = $clog2(NB_INPUTS);
  localparam int STOP_IDX     = stop_bit_idx(FLIT_WIDTH);

  hynoc_state_e            r_state, w_state_nxt;
  logic [NB_INPUTS-1:0]    r_grant;
  logic [IDX_W-1:0]        r_sel, r_last_winner;
  logic [CREDIT_WIDTH-1:0] r_credit_cnt;
  logic                    r_credit_err, r_out_valid;
  logic [FLIT_WIDTH-1:0]   r_out_data;

  logic [NB_INPUTS-1:0]    w_pick_onehot;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_any;
  logic                    w_has_credit, w_xfer, w_xfer_last, w_credit_full;
  logic [FLIT_WIDTH-1:0]   w_flits [NB_INPUTS];
  logic [FLIT_WIDTH-1:0]   w_sel_flit;

  for (genvar g = 0; g < NB_INPUTS; g++) begin : g_unpack
    assign w_flits[g] = bus.from_ingress_data[g*FLIT_WIDTH +: FLIT_WIDTH];
  end

  hynoc_rr_pick #(.NB_INPUTS(NB_INPUTS), .IDX_W(IDX_W)) u_rr_pick (
    .i_req         (bus.from_ingress_request),
    .i_last_winner (r_last_winner),
    .o_onehot      (w_pick_onehot),
    .o_idx         (w_pick_idx),
    .o_any         (w_pick_any)
  );

  assign w_sel_flit    = w_flits[r_sel];
  assign w_has_credit  = (r_credit_cnt != '0);
  assign w_credit_full = (r_credit_cnt == CREDIT_WIDTH'(CREDITS));
  assign w_xfer        = (r_state == ST_LOCKED) && bus.from_ingress_valid[r_sel] && w_has_credit;
  assign w_xfer_last   = w_xfer && w_sel_flit[STOP_IDX];

  // Grant is one-hot at r_sel while locked, so it doubles as the ready mask.
  assign bus.to_ingress_grant = r_grant;
  assign bus.to_ingress_ready = ((r_state == ST_LOCKED) && w_has_credit) ? r_grant : '0;
  assign bus.out_valid        = r_out_valid;
  assign bus.out_data         = r_out_data;
  assign bus.credit_err       = r_credit_err;

  always_ff @(posedge router_clk) begin
    if (router_srst) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_pick_any)  w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_xfer_last) w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge router_clk) begin
    if (router_srst) begin
      r_grant       <= '0;
      r_sel         <= '0;
      r_last_winner <= IDX_W'(NB_INPUTS - 1);
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_credit_cnt  <= CREDIT_WIDTH'(CREDITS);
      r_credit_err  <= 1'b0;
    end else begin
      r_out_valid <= w_xfer;
      if (w_xfer) r_out_data <= w_sel_flit;

      if ((r_state == ST_IDLE) && w_pick_any) begin
        r_grant <= w_pick_onehot;
        r_sel   <= w_pick_idx;
      end else if (w_xfer_last) begin
        r_grant       <= '0;
        r_last_winner <= r_sel;
      end

      // Simultaneous send and return cancel out; a return at full is an error, not an increment.
      case ({w_xfer, bus.credit_return})
        2'b10: r_credit_cnt <= r_credit_cnt - CREDIT_WIDTH'(1);
        2'b01: begin
          if (w_credit_full) r_credit_err <= 1'b1;
          else               r_credit_cnt <= r_credit_cnt + CREDIT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef HYNOC_EGRESS_STATS_EN
  logic [31:0] r_stat_flits, r_stat_packets;

  always_ff @(posedge router_clk) begin
    if (router_srst) begin
      r_stat_flits   <= '0;
      r_stat_packets <= '0;
    end else begin
      if (w_xfer)      r_stat_flits   <= r_stat_flits + 32'd1;
      if (w_xfer_last) r_stat_packets <= r_stat_packets + 32'd1;
    end
  end

  assign stat_flits   = r_stat_flits;
  assign stat_packets = r_stat_packets;
`endif

endmodule
